os2ip_stream: RTL and testbench



---
 rtl/os2ip_stream.sv | 102 ++++++++++
 tb/tb_os2ip_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/os2ip_stream.sv
// os2ip_stream -- Octet-String-to-Integer conversion (OS2IP) for the RSA datapath.
//
// Collects a big-endian octet string, one byte per ready/valid handshake, into a
// WIDTH-bit integer for the modular-exponentiation core. The first octet ends up
// most significant; short strings are zero-extended at the top. Octets beyond
// NBYTES are dropped and flagged with overflow.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous, active-high; clears all state
//   in_valid   in_byte / in_last are valid
//   in_ready   block accepts a byte this cycle (high only while accumulating)
//   in_byte    next octet, most significant first
//   in_last    marks the final octet of the string
//   out_valid  X / out_len / overflow hold a completed conversion
//   out_ready  consumer takes the result
//   X          assembled integer
//   out_len    number of octets stored in X
//   overflow   string was longer than NBYTES; the excess octets were dropped

module os2ip_stream #(
    parameter  int WIDTH  = 2048,
    localparam int NBYTES = WIDTH / 8,
    localparam int LEN_W  = $clog2(NBYTES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X,
    output logic [LEN_W-1:0] out_len,
    output logic             overflow
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] MAX_COUNT = LEN_W'(NBYTES);

    state_t           state;
    logic [LEN_W-1:0] count;

    // The octet count is the reported length; it only ever counts stored octets.
    assign out_len = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            X         <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    // in_ready is always high in ACCUM, so in_valid alone means accept.
                    if (in_valid) begin
                        if (count < MAX_COUNT) begin
                            // Shift accumulator: earlier octets migrate toward the MSB end.
                            X     <= {X[WIDTH-9:0], in_byte};
                            count <= count + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // Result is frozen until taken; clearing here gives the next
                    // string a clean accumulator, at the cost of one idle cycle.
                    if (out_ready) begin
                        state     <= ACCUM;
                        X         <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_os2ip_stream.sv
// tb_os2ip_stream -- self-checking bench for os2ip_stream at the default WIDTH.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected results come from a plain-arithmetic reference model over a byte queue.

module tb_os2ip_stream;

    localparam int WIDTH = 2048;
    localparam int NB    = WIDTH / 8;
    localparam int LW    = $clog2(NB) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_byte = 8'h00;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] X;
    logic [LW-1:0]    out_len;
    logic             overflow;

    int tests = 0;
    int fails = 0;

    os2ip_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X         (X),
        .out_len   (out_len),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: big-endian integer of the first NB octets, length capped at NB.
    function automatic void model(input logic [7:0] q[$], output logic [WIDTH-1:0] x,
                                  output int len, output logic ovf);
        x   = '0;
        len = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i < NB) begin
                x   = x * 256 + WIDTH'(q[i]);
                len = len + 1;
            end
        end
        ovf = (q.size() > NB);
    endfunction

    // Present one byte from a falling edge and hold it until it has been accepted.
    task automatic drive_byte(input logic [7:0] b, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic send_string(input logic [7:0] q[$], input int gapmax);
        for (int i = 0; i < q.size(); i++) begin
            repeat ($urandom_range(gapmax, 0)) @(negedge clk);
            drive_byte(q[i], (i == q.size() - 1));
        end
    endtask

    task automatic release_result(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (X !== '0) begin fails++; $display("FAIL reset_x: got %h, required 0", X[127:0]); end
        tests++; if (out_len !== '0) begin fails++; $display("FAIL reset_len: got %0d, required 0", out_len); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b, required 0", overflow); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        logic [WIDTH-1:0] ex;
        int el;
        logic eo;
        q = '{8'h04, 8'h03, 8'h02, 8'h01};
        model(q, ex, el, eo);
        for (int i = 0; i < 3; i++) drive_byte(q[i], 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b, required 0", out_valid); end
        drive_byte(q[3], 1'b1);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: out_valid=%b, required 1", out_valid); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready: got %b, required 0", in_ready); end
        tests++; if (X !== ex) begin fails++; $display("FAIL basic_x: got %h, required %h", X[127:0], ex[127:0]); end
        tests++; if (X[31:0] !== 32'h04030201) begin fails++; $display("FAIL basic_x_literal: got %h, required 04030201", X[31:0]); end
        tests++; if (out_len !== LW'(el)) begin fails++; $display("FAIL basic_len: got %0d, required %0d", out_len, el); end
        tests++; if (overflow !== eo) begin fails++; $display("FAIL basic_ovf: got %b, required %b", overflow, eo); end
        release_result(0);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL basic_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready); end
    endtask

    task automatic test_gaps_hold();
        logic [7:0] q[$];
        logic [WIDTH-1:0] ex;
        int el;
        logic eo;
        q = '{8'h04, 8'h03, 8'h02, 8'h01};
        model(q, ex, el, eo);
        send_string(q, 3);
        for (int c = 0; c < 5; c++) begin
            tests++; if (out_valid !== 1'b1 || X !== ex || out_len !== LW'(el)) begin
                fails++; $display("FAIL hold_stable c%0d: valid=%b x=%h len=%0d, required 1/%h/%0d", c, out_valid, X[63:0], out_len, ex[63:0], el);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_release: out_valid=%b, required 0", out_valid); end
        tests++; if (X !== '0 || out_len !== '0) begin fails++; $display("FAIL hold_clear: x=%h len=%0d, required 0/0", X[63:0], out_len); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] q[$];
            logic [WIDTH-1:0] ex;
            int el, len;
            logic eo;
            q   = {};
            len = $urandom_range(24, 1);
            for (int i = 0; i < len; i++) begin
                if ((n % 2 == 0 && i == 0) || $urandom_range(9, 0) < 3) q.push_back(8'h00);
                else q.push_back(8'($urandom));
            end
            model(q, ex, el, eo);
            send_string(q, 3);
            tests++; if (out_valid !== 1'b1 || X !== ex) begin fails++; $display("FAIL rand%0d_x: valid=%b x=%h, required 1/%h", n, out_valid, X[127:0], ex[127:0]); end
            tests++; if (out_len !== LW'(el) || overflow !== eo) begin fails++; $display("FAIL rand%0d_len: len=%0d ovf=%b, required %0d/%b", n, out_len, overflow, el, eo); end
            release_result($urandom_range(3, 0));
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rand%0d_release: in_ready=%b, required 1", n, in_ready); end
        end
    endtask

    task automatic test_full_and_overflow(input int total);
        logic [7:0] q[$];
        logic [WIDTH-1:0] ex;
        int el;
        logic eo;
        q = {};
        for (int i = 0; i < total; i++) q.push_back(8'(i + 1));
        model(q, ex, el, eo);
        send_string(q, 0);
        tests++; if (X !== ex) begin fails++; $display("FAIL len%0d_x: got %h, required %h", total, X[127:0], ex[127:0]); end
        tests++; if (X[WIDTH-1:WIDTH-8] !== 8'h01 || X[7:0] !== 8'h00) begin fails++; $display("FAIL len%0d_ends: top=%h bottom=%h, required 01/00", total, X[WIDTH-1:WIDTH-8], X[7:0]); end
        tests++; if (out_len !== LW'(NB)) begin fails++; $display("FAIL len%0d_len: got %0d, required %0d", total, out_len, NB); end
        tests++; if (overflow !== eo) begin fails++; $display("FAIL len%0d_ovf: got %b, required %b", total, overflow, eo); end
        release_result(1);
        tests++; if (in_ready !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL len%0d_release: in_ready=%b ovf=%b, required 1/0", total, in_ready, overflow); end
    endtask

    task automatic test_reset_mid();
        drive_byte(8'hAA, 1'b0);
        drive_byte(8'hBB, 1'b0);
        tests++; if (X[15:0] !== 16'hAABB) begin fails++; $display("FAIL mid_partial: got %h, required aabb", X[15:0]); end
        reset = 1'b1;
        #1;
        tests++; if (X !== '0 || out_len !== '0) begin fails++; $display("FAIL mid_reset_x: x=%h len=%0d, required 0/0", X[63:0], out_len); end
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_hs: valid=%b ready=%b, required 0/1", out_valid, in_ready); end
        #2;
        reset = 1'b0;
        @(negedge clk);
        drive_byte(8'hAB, 1'b1);
        tests++; if (out_valid !== 1'b1 || X !== WIDTH'(8'hAB)) begin fails++; $display("FAIL mid_single_x: valid=%b x=%h, required 1/ab", out_valid, X[63:0]); end
        tests++; if (out_len !== LW'(1) || overflow !== 1'b0) begin fails++; $display("FAIL mid_single_len: len=%0d ovf=%b, required 1/0", out_len, overflow); end
        release_result(0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive_byte(8'h00, 1'b0);
        drive_byte(8'h7F, 1'b1);
        tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL b2b_first_hs: valid=%b ready=%b, required 1/0", out_valid, in_ready); end
        tests++; if (X !== WIDTH'(8'h7F) || out_len !== LW'(2) || overflow !== 1'b0) begin fails++; $display("FAIL b2b_first: x=%h len=%0d ovf=%b, required 7f/2/0", X[63:0], out_len, overflow); end
        // Second string is offered during the idle cycle; it must not be taken yet.
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        in_last  = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || X !== '0) begin fails++; $display("FAIL b2b_idle: valid=%b ready=%b x=%h, required 0/1/0", out_valid, in_ready, X[63:0]); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || X !== WIDTH'(8'hFF)) begin fails++; $display("FAIL b2b_second_x: valid=%b x=%h, required 1/ff", out_valid, X[63:0]); end
        tests++; if (out_len !== LW'(1) || overflow !== 1'b0) begin fails++; $display("FAIL b2b_second_len: len=%0d ovf=%b, required 1/0", out_len, overflow); end
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_done: valid=%b ready=%b, required 0/1", out_valid, in_ready); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps_hold();
        test_random();
        test_full_and_overflow(NB);
        test_full_and_overflow(NB + 2);
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
